// File: rtl/jbi_ssi_ucb_mstr.sv
// Requester end of the 4-bit UCB link to the JBI SSI block: serializes read/write
// requests onto the link and buffers returning read-ack/nack/interrupt packets.
module jbi_ssi_ucb_mstr #(
    parameter int unsigned       TOUT_W   = 16,
    parameter logic [TOUT_W-1:0] TOUT_VAL = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        req_vld,
    input  logic        req_rw,
    input  logic [4:0]  req_thr,
    input  logic [1:0]  req_buf,
    input  logic [2:0]  req_size,
    input  logic [39:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_acpt,
    output logic        iob_jbi_spi_vld,
    output logic [3:0]  iob_jbi_spi_data,
    input  logic        jbi_iob_spi_stall,
    input  logic        jbi_iob_spi_vld,
    input  logic [3:0]  jbi_iob_spi_data,
    output logic        iob_jbi_spi_stall,
    output logic        rsp_vld,
    output logic [3:0]  rsp_type,
    output logic [4:0]  rsp_thr,
    output logic [1:0]  rsp_buf,
    output logic [63:0] rsp_data,
    output logic        rsp_tout,
    input  logic        rsp_accpt
);

    localparam int unsigned PKT_W = 128;
    localparam int unsigned CNT_W = 5;

    localparam logic [3:0] T_RD_REQ  = 4'b0100;
    localparam logic [3:0] T_WR_REQ  = 4'b0101;
    localparam logic [3:0] T_RD_ACK  = 4'b0001;
    localparam logic [3:0] T_RD_NACK = 4'b0000;
    localparam logic [3:0] T_INT     = 4'b1000;

    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_HOLD} rx_state_e;

    tx_state_e          tx_state_q, tx_state_d;
    logic [PKT_W-1:0]   tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               tx_rd_q, tx_rd_d;
    logic               req_acpt_q, req_acpt_d;
    logic               spi_vld_q, spi_vld_d;
    logic [3:0]         spi_data_q, spi_data_d;
    logic [4:0]         sv_thr_q, sv_thr_d;
    logic [1:0]         sv_buf_q, sv_buf_d;
    logic               rd_out_q, rd_out_d;
    logic               tout_arm_q, tout_arm_d;
    logic [TOUT_W-1:0]  tout_cnt_q, tout_cnt_d;
    rx_state_e          rx_state_q, rx_state_d;
    logic [PKT_W-1:0]   rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic               rx_ack_q, rx_ack_d;
    logic               stall_q, stall_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [3:0]         rsp_type_q, rsp_type_d;
    logic [4:0]         rsp_thr_q, rsp_thr_d;
    logic [1:0]         rsp_buf_q, rsp_buf_d;
    logic [63:0]        rsp_data_q, rsp_data_d;
    logic               rsp_tout_q, rsp_tout_d;

    logic               rd_set_c, tx_rd_last_c, rx_done_c, rx_known_c, rx_load_c, tout_pend_c;
    logic [3:0]         rx_type_c;
    logic [63:0]        hdr_c;

    assign hdr_c = {9'd0, req_addr, req_size, 1'b0, req_buf, req_thr,
                    (req_rw ? T_RD_REQ : T_WR_REQ)};

    // Transmit FSM: latch request, then shift it out one nibble per cycle
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_sh_d      = tx_sh_q;
        tx_cnt_d     = tx_cnt_q;
        tx_rd_d      = tx_rd_q;
        sv_thr_d     = sv_thr_q;
        sv_buf_d     = sv_buf_q;
        req_acpt_d   = 1'b0;
        spi_vld_d    = 1'b0;
        spi_data_d   = 4'd0;
        rd_set_c     = 1'b0;
        tx_rd_last_c = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (req_vld && !jbi_iob_spi_stall && !rd_out_q) begin
                    req_acpt_d = 1'b1;
                    tx_sh_d    = {(req_rw ? 64'd0 : req_wdata), hdr_c};
                    tx_cnt_d   = '0;
                    tx_rd_d    = req_rw;
                    tx_state_d = TX_SEND;
                    if (req_rw) begin
                        rd_set_c = 1'b1;
                        sv_thr_d = req_thr;
                        sv_buf_d = req_buf;
                    end
                end
            end
            TX_SEND: begin
                spi_vld_d  = 1'b1;
                spi_data_d = tx_sh_q[3:0];
                tx_sh_d    = {4'd0, tx_sh_q[PKT_W-1:4]};
                tx_cnt_d   = tx_cnt_q + CNT_W'(1);
                if (tx_cnt_q == (tx_rd_q ? CNT_W'(15) : CNT_W'(31))) begin
                    tx_state_d   = TX_IDLE;
                    tx_rd_last_c = tx_rd_q;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Receive FSM; a completed packet waits in HOLD while the buffer is occupied
    always_comb begin
        rx_state_d = rx_state_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_ack_d   = rx_ack_q;
        rx_done_c  = 1'b0;
        rx_load_c  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (jbi_iob_spi_vld) begin
                    rx_sh_d      = '0;
                    rx_sh_d[3:0] = jbi_iob_spi_data;
                    rx_cnt_d     = CNT_W'(1);
                    rx_ack_d     = (jbi_iob_spi_data == T_RD_ACK);
                    rx_state_d   = RX_RECV;
                end
            end
            RX_RECV: begin
                if (jbi_iob_spi_vld) begin
                    rx_sh_d[{rx_cnt_q, 2'b00} +: 4] = jbi_iob_spi_data;
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    rx_done_c = (rx_cnt_q == (rx_ack_q ? CNT_W'(31) : CNT_W'(15)));
                end
            end
            RX_HOLD: rx_done_c = 1'b1;
            default: rx_state_d = RX_IDLE;
        endcase
        rx_type_c  = rx_sh_d[3:0];
        rx_known_c = (rx_type_c == T_RD_ACK) || (rx_type_c == T_RD_NACK) || (rx_type_c == T_INT);
        if (rx_done_c) begin
            if (!rx_known_c) begin
                rx_state_d = RX_IDLE;
            end else if (!rsp_vld_q) begin
                rx_load_c  = 1'b1;
                rx_state_d = RX_IDLE;
            end else begin
                rx_state_d = RX_HOLD;
            end
        end
    end

    // Response buffer, read-outstanding flag, timeout and outbound stall
    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_type_d = rsp_type_q;
        rsp_thr_d  = rsp_thr_q;
        rsp_buf_d  = rsp_buf_q;
        rsp_data_d = rsp_data_q;
        rsp_tout_d = rsp_tout_q;
        rd_out_d   = rd_out_q;
        tout_arm_d = tout_arm_q;
        tout_cnt_d = tout_cnt_q;
        tout_pend_c = tout_arm_q && (tout_cnt_q == TOUT_VAL);
        if (rsp_vld_q && rsp_accpt) rsp_vld_d = 1'b0;
        if (tout_arm_q && !tout_pend_c) tout_cnt_d = tout_cnt_q + TOUT_W'(1);
        if (rx_load_c) begin
            rsp_vld_d  = 1'b1;
            rsp_type_d = rx_type_c;
            rsp_thr_d  = rx_sh_d[8:4];
            rsp_buf_d  = rx_sh_d[10:9];
            rsp_data_d = (rx_type_c == T_RD_ACK) ? rx_sh_d[127:64] : 64'd0;
            rsp_tout_d = 1'b0;
            if (rx_type_c != T_INT) begin
                rd_out_d   = 1'b0;
                tout_arm_d = 1'b0;
                tout_cnt_d = '0;
            end
        end else if (tout_pend_c && !rsp_vld_q) begin
            rsp_vld_d  = 1'b1;
            rsp_type_d = T_RD_NACK;
            rsp_thr_d  = sv_thr_q;
            rsp_buf_d  = sv_buf_q;
            rsp_data_d = 64'd0;
            rsp_tout_d = 1'b1;
            rd_out_d   = 1'b0;
            tout_arm_d = 1'b0;
            tout_cnt_d = '0;
        end
        if (tx_rd_last_c) begin
            tout_arm_d = 1'b1;
            tout_cnt_d = '0;
        end
        if (rd_set_c) rd_out_d = 1'b1;
        stall_d = (rx_state_d != RX_IDLE) || rsp_vld_q || rsp_vld_d || tout_pend_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            tx_rd_q    <= 1'b0;
            req_acpt_q <= 1'b0;
            spi_vld_q  <= 1'b0;
            spi_data_q <= 4'd0;
            sv_thr_q   <= 5'd0;
            sv_buf_q   <= 2'd0;
            rd_out_q   <= 1'b0;
            tout_arm_q <= 1'b0;
            tout_cnt_q <= '0;
            rx_state_q <= RX_IDLE;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_ack_q   <= 1'b0;
            stall_q    <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_type_q <= 4'd0;
            rsp_thr_q  <= 5'd0;
            rsp_buf_q  <= 2'd0;
            rsp_data_q <= 64'd0;
            rsp_tout_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_rd_q    <= tx_rd_d;
            req_acpt_q <= req_acpt_d;
            spi_vld_q  <= spi_vld_d;
            spi_data_q <= spi_data_d;
            sv_thr_q   <= sv_thr_d;
            sv_buf_q   <= sv_buf_d;
            rd_out_q   <= rd_out_d;
            tout_arm_q <= tout_arm_d;
            tout_cnt_q <= tout_cnt_d;
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_ack_q   <= rx_ack_d;
            stall_q    <= stall_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_type_q <= rsp_type_d;
            rsp_thr_q  <= rsp_thr_d;
            rsp_buf_q  <= rsp_buf_d;
            rsp_data_q <= rsp_data_d;
            rsp_tout_q <= rsp_tout_d;
        end
    end

    assign req_acpt          = req_acpt_q;
    assign iob_jbi_spi_vld   = spi_vld_q;
    assign iob_jbi_spi_data  = spi_data_q;
    assign iob_jbi_spi_stall = stall_q;
    assign rsp_vld           = rsp_vld_q;
    assign rsp_type          = rsp_type_q;
    assign rsp_thr           = rsp_thr_q;
    assign rsp_buf           = rsp_buf_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_tout          = rsp_tout_q;

endmodule

// File: tb/tb_jbi_ssi_ucb_mstr.sv
// Directed bench for jbi_ssi_ucb_mstr: request serialization, response buffering,
// one-outstanding-read rule, timeout nack and response-buffer backpressure.
module tb_jbi_ssi_ucb_mstr;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        req_vld, req_rw;
    logic [4:0]  req_thr;
    logic [1:0]  req_buf;
    logic [2:0]  req_size;
    logic [39:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_acpt;
    logic        iob_jbi_spi_vld;
    logic [3:0]  iob_jbi_spi_data;
    logic        jbi_iob_spi_stall;
    logic        jbi_iob_spi_vld;
    logic [3:0]  jbi_iob_spi_data;
    logic        iob_jbi_spi_stall;
    logic        rsp_vld;
    logic [3:0]  rsp_type;
    logic [4:0]  rsp_thr;
    logic [1:0]  rsp_buf;
    logic [63:0] rsp_data;
    logic        rsp_tout;
    logic        rsp_accpt;

    int n_chk = 0;
    int n_err = 0;

    jbi_ssi_ucb_mstr #(.TOUT_W(16), .TOUT_VAL(16'd20)) u_dut (
        .clk(clk), .rst_l(rst_l),
        .req_vld(req_vld), .req_rw(req_rw), .req_thr(req_thr), .req_buf(req_buf),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_acpt(req_acpt),
        .iob_jbi_spi_vld(iob_jbi_spi_vld), .iob_jbi_spi_data(iob_jbi_spi_data),
        .jbi_iob_spi_stall(jbi_iob_spi_stall), .jbi_iob_spi_vld(jbi_iob_spi_vld),
        .jbi_iob_spi_data(jbi_iob_spi_data), .iob_jbi_spi_stall(iob_jbi_spi_stall),
        .rsp_vld(rsp_vld), .rsp_type(rsp_type), .rsp_thr(rsp_thr), .rsp_buf(rsp_buf),
        .rsp_data(rsp_data), .rsp_tout(rsp_tout), .rsp_accpt(rsp_accpt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic rw, input logic [4:0] thr, input logic [1:0] bf,
                           input logic [2:0] sz, input logic [39:0] addr, input logic [63:0] wd);
        req_rw = rw; req_thr = thr; req_buf = bf; req_size = sz; req_addr = addr; req_wdata = wd;
        req_vld = 1'b1;
    endtask

    task automatic wait_acpt(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_acpt) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    // Collect n outbound nibbles, LSB nibble first; bad counts cycles without vld
    task automatic collect_pkt(input int n, output logic [127:0] pkt, output int bad);
        pkt = '0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (!iob_jbi_spi_vld) bad++;
            pkt[i*4 +: 4] = iob_jbi_spi_data;
            tick();
        end
    endtask

    // Drive n inbound nibbles; st1 is the stall output one cycle after the first
    task automatic send_pkt(input logic [127:0] pkt, input int n, output logic st1);
        st1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            jbi_iob_spi_vld  = 1'b1;
            jbi_iob_spi_data = pkt[i*4 +: 4];
            tick();
            if (i == 0) st1 = iob_jbi_spi_stall;
        end
        jbi_iob_spi_vld  = 1'b0;
        jbi_iob_spi_data = 4'd0;
    endtask

    task automatic pop_rsp();
        rsp_accpt = 1'b1;
        tick();
        rsp_accpt = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pkt;
        int           bad, viol, cyc;
        logic         st1;

        rst_l = 1'b0; req_vld = 1'b0; req_rw = 1'b0; req_thr = '0; req_buf = '0;
        req_size = '0; req_addr = '0; req_wdata = '0; jbi_iob_spi_stall = 1'b0;
        jbi_iob_spi_vld = 1'b0; jbi_iob_spi_data = '0; rsp_accpt = 1'b0;
        repeat (3) tick();
        check("rst_acpt",  64'(req_acpt), 64'd0);
        check("rst_vld",   64'(iob_jbi_spi_vld), 64'd0);
        check("rst_data",  64'(iob_jbi_spi_data), 64'd0);
        check("rst_stall", 64'(iob_jbi_spi_stall), 64'd0);
        check("rst_rsp",   {rsp_type, rsp_thr, rsp_buf, rsp_vld, rsp_tout}, 64'd0);
        check("rst_rdata", rsp_data, 64'd0);
        rst_l = 1'b1;
        tick();

        // Write: 32 nibbles, header then data beat, no response
        set_req(1'b0, 5'h02, 2'h0, 3'h3, 40'h00_FFF0_0008, 64'hDEAD_BEEF_0123_4567);
        wait_acpt("wr_acpt");
        req_vld = 1'b0;
        tick();
        collect_pkt(32, pkt, bad);
        check("wr_vld_cont", 64'(bad), 64'd0);
        check("wr_type",  64'(pkt[3:0]), 64'h5);
        check("wr_hdr",   pkt[63:0], 64'h0000_7FF8_0004_3025);
        check("wr_data",  pkt[127:64], 64'hDEAD_BEEF_0123_4567);
        check("wr_end_vld", 64'(iob_jbi_spi_vld), 64'd0);
        repeat (25) tick();
        check("wr_no_rsp", 64'(rsp_vld), 64'd0);

        // Read thr 3 buf 1, READ_ACK returned while the request is still going out
        set_req(1'b1, 5'h03, 2'h1, 3'h0, 40'h00_0000_0100, 64'h0);
        wait_acpt("rd_acpt");
        req_vld = 1'b0;
        tick();
        fork
            collect_pkt(16, pkt, bad);
            send_pkt({64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0231}, 32, st1);
        join
        check("rd_vld_cont", 64'(bad), 64'd0);
        check("rd_hdr",   pkt[63:0], 64'h0000_0000_0080_0234);
        check("rd_len",   pkt[127:64], 64'd0);
        check("ack_stall_rise", 64'(st1), 64'd1);
        check("ack_vld",  64'(rsp_vld), 64'd1);
        check("ack_type", 64'(rsp_type), 64'h1);
        check("ack_tb",   {rsp_thr, rsp_buf}, {57'd0, 5'h03, 2'h1});
        check("ack_data", rsp_data, 64'h0123_4567_89AB_CDEF);
        check("ack_tout", 64'(rsp_tout), 64'd0);
        pop_rsp();
        check("pop_vld",  64'(rsp_vld), 64'd0);
        check("pop_stall_n1", 64'(iob_jbi_spi_stall), 64'd1);
        tick();
        check("pop_stall_n2", 64'(iob_jbi_spi_stall), 64'd0);

        // Read A with link stall held high for 10 cycles
        jbi_iob_spi_stall = 1'b1;
        set_req(1'b1, 5'h01, 2'h0, 3'h7, 40'h12_3456_7890, 64'h0);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_acpt || iob_jbi_spi_vld) viol++;
            tick();
        end
        check("stall_hold", 64'(viol), 64'd0);
        jbi_iob_spi_stall = 1'b0;
        check("stall_drop_acpt", 64'(req_acpt), 64'd0);
        tick();
        check("stall_acpt_next", 64'(req_acpt), 64'd1);
        check("stall_vld_low", 64'(iob_jbi_spi_vld), 64'd0);
        req_vld = 1'b0;
        tick();
        collect_pkt(16, pkt, bad);
        check("rdA_vld_cont", 64'(bad), 64'd0);
        check("rdA_hdr", pkt[63:0], 64'h0009_1A2B_3C48_7014);

        // Read B waits while A is outstanding; A answered by READ_NACK
        set_req(1'b1, 5'h07, 2'h2, 3'h0, 40'h00_0000_0040, 64'h0);
        viol = 0;
        fork
            send_pkt({64'd0, 64'h0000_0000_0000_0010}, 16, st1);
            for (int i = 0; i < 16; i++) begin
                if (req_acpt) viol++;
                tick();
            end
        join
        check("rdB_blocked", 64'(viol), 64'd0);
        check("nack_vld",  64'(rsp_vld), 64'd1);
        check("nack_type", 64'(rsp_type), 64'h0);
        check("nack_tb",   {rsp_thr, rsp_buf}, {57'd0, 5'h01, 2'h0});
        check("nack_tout", 64'(rsp_tout), 64'd0);
        check("rdB_acpt_early", 64'(req_acpt), 64'd0);
        pop_rsp();
        check("rdB_acpt", 64'(req_acpt), 64'd1);
        req_vld = 1'b0;
        tick();
        collect_pkt(16, pkt, bad);
        check("rdB_hdr", pkt[63:0], 64'h0000_0000_0020_0474);

        // Read B gets no response: timeout nack 21 cycles after its last nibble
        cyc = 1;
        for (int i = 0; i < 60 && !rsp_vld; i++) begin
            tick();
            cyc++;
        end
        check("tout_cycles", 64'(cyc), 64'd21);
        check("tout_type",  64'(rsp_type), 64'h0);
        check("tout_flag",  64'(rsp_tout), 64'd1);
        check("tout_tb",    {rsp_thr, rsp_buf}, {57'd0, 5'h07, 2'h2});
        check("tout_data",  rsp_data, 64'd0);
        check("tout_stall", 64'(iob_jbi_spi_stall), 64'd1);
        pop_rsp();
        tick();

        // Unsolicited NACK held in buffer; INT arrives behind it
        send_pkt({64'd0, 64'h0000_0000_0000_0690}, 16, st1);
        check("un_nack_vld", 64'(rsp_vld), 64'd1);
        check("un_nack_thr", 64'(rsp_thr), 64'h09);
        check("full_stall",  64'(iob_jbi_spi_stall), 64'd1);
        send_pkt({64'd0, 64'h0000_0000_0000_05A8}, 16, st1);
        tick();
        check("hold_type", 64'(rsp_type), 64'h0);
        check("hold_tb",   {rsp_thr, rsp_buf}, {57'd0, 5'h09, 2'h3});
        check("hold_stall", 64'(iob_jbi_spi_stall), 64'd1);
        pop_rsp();
        check("hold_pop_vld", 64'(rsp_vld), 64'd0);
        tick();
        check("int_vld",  64'(rsp_vld), 64'd1);
        check("int_type", 64'(rsp_type), 64'h8);
        check("int_tb",   {rsp_thr, rsp_buf}, {57'd0, 5'h1A, 2'h2});
        check("int_data", rsp_data, 64'd0);
        check("int_tout", 64'(rsp_tout), 64'd0);
        pop_rsp();
        tick();
        check("int_stall_clear", 64'(iob_jbi_spi_stall), 64'd0);

        // Unknown type is consumed and dropped
        send_pkt({64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0233}, 16, st1);
        check("unk_stall_during", 64'(st1), 64'd1);
        check("unk_no_rsp", 64'(rsp_vld), 64'd0);
        check("unk_stall",  64'(iob_jbi_spi_stall), 64'd0);

        // Reset in the middle of an outbound write
        set_req(1'b0, 5'h04, 2'h1, 3'h1, 40'h00_0000_1000, 64'h1111_2222_3333_4444);
        wait_acpt("mid_acpt");
        req_vld = 1'b0;
        repeat (3) tick();
        check("mid_vld_before", 64'(iob_jbi_spi_vld), 64'd1);
        rst_l = 1'b0;
        tick();
        check("mid_rst_vld",  64'(iob_jbi_spi_vld), 64'd0);
        check("mid_rst_data", 64'(iob_jbi_spi_data), 64'd0);
        rst_l = 1'b1;
        repeat (2) tick();
        check("mid_after_vld", 64'(iob_jbi_spi_vld), 64'd0);
        check("mid_after_acpt", 64'(req_acpt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/jbi_ssi_ucb_mstr.md
# jbi_ssi_ucb_mstr

Requester end of the 4-bit narrow UCB link that feeds the JBI SSI (boot-ROM) block: serializes read/write request packets from a parallel request port onto the nibble link, and deserializes read-ack/nack and interrupt packets returning from the SSI block into a single-entry response buffer. It sits on the IOB side of the `iob_jbi_spi_*` / `jbi_iob_spi_*` wires and is used as the IOB narrow-link port and as the emulation driver for the SSI path. It allows one outstanding read and enforces a read timeout.

## Interface
- TOUT_W, 16: width of the read-timeout counter.
- TOUT_VAL, 16'hFFFF: cycles from last request nibble to synthetic timeout nack.
- clk  in  1  JBus clock.
- rst_l  in  1  synchronous active-low reset.
- req_vld  in  1  request present; held until req_acpt.
- req_rw  in  1  1 = read (READ_REQ), 0 = write (WRITE_REQ).
- req_thr  in  5  thread id.
- req_buf  in  2  buffer id.
- req_size  in  3  size field.
- req_addr  in  40  address.
- req_wdata  in  64  write data.
- req_acpt  out  1  one-cycle pulse; request captured.
- iob_jbi_spi_vld  out  1  outbound nibble valid.
- iob_jbi_spi_data  out  4  outbound nibble.
- jbi_iob_spi_stall  in  1  receiver flow control.
- jbi_iob_spi_vld  in  1  inbound nibble valid.
- jbi_iob_spi_data  in  4  inbound nibble.
- iob_jbi_spi_stall  out  1  flow control to SSI block.
- rsp_vld  out  1  response buffer full.
- rsp_type  out  4  packet type field.
- rsp_thr  out  5  thread id.
- rsp_buf  out  2  buffer id.
- rsp_data  out  64  payload (zero for nack/interrupt).
- rsp_tout  out  1  response is a synthetic timeout nack.
- rsp_accpt  in  1  consumer pops buffer.

## Operation
- Header layout (64 b): [3:0] type, [8:4] thr, [10:9] buf, [14:12] size, [54:15] addr, rest 0. Data beat bits [127:64].
- Types: READ_REQ 4'b0100, WRITE_REQ 4'b0101, READ_ACK 4'b0001, READ_NACK 4'b0000, INT 4'b1000.
- TX FSM: IDLE -> SEND -> IDLE. In IDLE, req_acpt asserted when req_vld, stall sampled low, and no read outstanding; packet latched into a 128-b shift register.
- SEND: one nibble per cycle, LSB nibble first, vld high continuously; read = 16 nibbles, write = 32 nibbles. Stall ignored once packet started.
- Read outstanding flag set at read req_acpt; cleared when READ_ACK/READ_NACK is buffered or on timeout. Writes never outstanding, generate no response.
- Timeout counter starts at last read nibble; reaching TOUT_VAL loads buffer with type READ_NACK, saved thr/buf, rsp_tout=1. If buffer is full at expiry, counter holds until free.
- RX FSM: IDLE -> RECV -> IDLE. First vld nibble is type; length 32 nibbles for READ_ACK, 16 otherwise. Nibbles shift in LSB first. On last nibble, fields move to response buffer.
- READ_ACK/NACK with no read outstanding: buffered anyway, flag unchanged.
- Unknown type: 16 nibbles consumed, discarded.
- iob_jbi_spi_stall = registered (RECV active OR rsp_vld OR timeout pending).
- Timeout and real response in same cycle: real response wins, counter cleared.

## Timing
- Reset: req_acpt, iob_jbi_spi_vld, iob_jbi_spi_stall, rsp_vld, rsp_tout = 0; iob_jbi_spi_data, rsp_type/thr/buf/data = 0; both FSMs IDLE; outstanding flag and counter cleared. Reset mid-packet aborts it with no partial output.
- req_acpt in cycle N -> first nibble (type) on link in N+1; back-to-back requests: next req_acpt no earlier than cycle after last nibble.
- Last inbound nibble in cycle N -> rsp_vld high in N+1.
- rsp_accpt with rsp_vld in N -> rsp_vld low in N+1; stall low in N+2 if RX idle.
- Stall rises the cycle after first inbound nibble.

## Test plan
- Write addr 40'h00_FFF0_0008, wdata 64'hDEAD_BEEF_0123_4567 -> 32 nibbles, first 4'h5, nibbles 16..31 = 7,6,5,4,3,2,1,0,F,E,E,B,D,A,E,D; no response.
- Read thr 5'h03 buf 2'h1 -> 16 nibbles first 4'h4; inject READ_ACK data 64'h0123_4567_89AB_CDEF -> rsp_vld, rsp_type 4'h1, rsp_data matches, rsp_tout 0.
- Read with stall held high 10 cycles -> req_acpt and vld stay low until cycle after stall drops.
- Read, no response, TOUT_VAL=16'd20 -> rsp_vld 21 cycles after last nibble, type 4'h0, rsp_tout 1, thr/buf echoed.
- Second read while first outstanding -> req_acpt held low until ack buffered.
- INT packet arrives while rsp_vld held -> stall high, packet not overwritten; after rsp_accpt second response delivered intact.
